// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
// Latency: none; this is wiring only.
// Backpressure: the master holds imem_req/imem_addr steady until the slave pulses imem_ack.
// Signals:
//   imem_req  - fetch request (master -> slave)
//   imem_addr - word-aligned fetch address (master -> slave)
//   imem_ack  - response valid this cycle (slave -> master)
//   imem_data - instruction word, valid with imem_ack (slave -> master)
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ack imem port and feeds ID.
// Latency: an instruction reaches the ID outputs one clk after its imem_ack (1 instr/clk with 1-cycle ack).
// Backpressure: if_en=0 parks one response in a 1-entry buffer (HOLD); at most one request is ever outstanding.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   if_rst, if_en    - controller restart (sync) and stage enable
//   redirect(_pc)    - taken branch/jump and its target (bits [1:0] are dropped)
//   imem             - instruction-memory handshake (master side)
//   inst_id, pc_id, pc4_id, if_valid - instruction, its PC and PC+4, validity, towards ID
//   fetch_pending    - a request is outstanding (FETCH or DROP)
//   perf_fetch_cnt, perf_drop_cnt - delivered / discarded counts
// Optional feature: define FETCH_PERF_CNT_EN to build the two performance counters;
// without it both counter ports read as zero.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_rst,
    input  logic                   if_en,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            inst_id,
    output logic [31:0]            pc_id,
    output logic [31:0]            pc4_id,
    output logic                   if_valid,
    output logic                   fetch_pending,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_drop_cnt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request on the bus, waiting for ack
        ST_HOLD  = 2'd1,   // response parked in buf_dat, waiting for if_en
        ST_DROP  = 2'd2    // one stale response is still owed and will be thrown away
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_dat;
    logic        ack;
    logic        flush_nxt_drop;

    assign ack = imem.imem_ack;

    // req/addr decode straight from the state register, so the address is frozen
    // for as long as a request sits in FETCH.
    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign fetch_pending  = (state == ST_FETCH) || (state == ST_DROP);

    // On if_rst or redirect, a request that is on the bus and not yet answered
    // still owes a response; that response must be swallowed in DROP.
    assign flush_nxt_drop = (state != ST_HOLD) && !ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            buf_dat  <= INST_NOP;
            inst_id  <= INST_NOP;
            pc_id    <= 32'h0000_0000;
            pc4_id   <= 32'h0000_0004;
            if_valid <= 1'b0;
        end else if (if_rst) begin
            pc       <= RESET_PC;
            buf_dat  <= INST_NOP;
            inst_id  <= INST_NOP;
            if_valid <= 1'b0;
            state    <= flush_nxt_drop ? ST_DROP : ST_FETCH;
        end else if (redirect) begin
            pc      <= redirect_pc & ~32'h3;
            buf_dat <= INST_NOP;
            state   <= flush_nxt_drop ? ST_DROP : ST_FETCH;
            if (if_en) begin
                inst_id  <= INST_NOP;
                if_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ack) begin
                        if (if_en) begin
                            inst_id  <= imem.imem_data;
                            pc_id    <= pc;
                            pc4_id   <= pc + 32'h4;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'h4;
                        end else begin
                            buf_dat <= imem.imem_data;
                            state   <= ST_HOLD;
                        end
                    end else if (if_en) begin
                        inst_id  <= INST_NOP;
                        if_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (if_en) begin
                        inst_id  <= buf_dat;
                        pc_id    <= pc;
                        pc4_id   <= pc + 32'h4;
                        if_valid <= 1'b1;
                        pc       <= pc + 32'h4;
                        state    <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (ack) begin
                        state <= ST_FETCH;
                    end
                    if (if_en) begin
                        inst_id  <= INST_NOP;
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic deliver;
    logic discard;

    // Mirrors the priority of the state machine above: a flush discards whatever
    // response is in hand (parked buffer or same-cycle ack); otherwise only a
    // delivery to ID or the owed response in DROP counts.
    always_comb begin
        deliver = 1'b0;
        discard = 1'b0;
        if (if_rst || redirect) begin
            discard = (state == ST_HOLD) || ack;
        end else begin
            deliver = if_en && (((state == ST_FETCH) && ack) || (state == ST_HOLD));
            discard = (state == ST_DROP) && ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0;
            perf_drop_cnt  <= 32'h0;
        end else begin
            if (deliver) perf_fetch_cnt <= perf_fetch_cnt + 32'h1;
            if (discard) perf_drop_cnt  <= perf_drop_cnt + 32'h1;
        end
    end
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_drop_cnt  = 32'h0;
`endif

endmodule
